burst_addr_gen: RTL and testbench
=================================

Name: burst_addr_gen

Overview:
Parametrised burst address generator for the DDR controller command path. It is the successor to the single-step address incrementer. It accepts one burst descriptor (start address, length, mode) and emits one beat address per valid/ready handshake, in INCR, WRAP or FIXED order. It sits between the request front-end and the column-command scheduler, and carries back-pressure from the scheduler.

Parameters:
ADDR_W, 32, address width in bits
LEN_W, 8, burst length field width; length encoded as beats-1
BEAT_BYTES, 8, bytes per beat; power of two, 1..128; address step per beat

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous active-low reset
start_valid  input  1  descriptor valid
start_ready  output  1  generator can accept a descriptor
start_addr  input  ADDR_W  first beat address
start_len  input  LEN_W  beats minus one
start_mode  input  2  00 INCR, 01 WRAP, 10 FIXED, 11 reserved (treated as INCR)
abort  input  1  synchronous burst cancel
addr_valid  output  1  addr_out valid
addr_ready  input  1  downstream accepts beat
addr_out  output  ADDR_W  current beat address
addr_last  output  1  current beat is final beat of burst
beat_idx  output  LEN_W  index of current beat, 0-based
busy  output  1  burst in progress (state ACTIVE)

Behaviour:
- Reset: the interface is one clock, with synchronous active-low reset n_rst sampled on the rising clk edge. Reset forces state IDLE and sets:
  - start_ready=1 in the cycle after reset is deasserted (it is 0 while n_rst=0);
  - addr_valid=0, addr_out=0, addr_last=0, beat_idx=0, busy=0.
- States:
  - IDLE: start_ready=1, addr_valid=0.
  - ACTIVE: start_ready=0, addr_valid=1, busy=1.
- IDLE->ACTIVE on start_valid&&start_ready.
  - The descriptor is latched at that edge.
  - On the next cycle, addr_out=start_addr, beat_idx=0, addr_valid=1. Latency is 1 cycle from accept to first beat.
- Beat advance: occurs only on addr_valid&&addr_ready. beat_idx increments and addr_out takes the next address.
  - While addr_ready=0, addr_out, addr_last, beat_idx and addr_valid hold stable.
- addr_last=1 exactly when beat_idx==latched len.
- Handshake on the last beat -> IDLE next cycle.
  - addr_valid drops and start_ready rises.
  - There is one bubble cycle between bursts; no overlap.
- len=0: single beat with addr_last=1 on the first beat.
- Address arithmetic, all modulo 2^ADDR_W:
  - INCR: next = addr + BEAT_BYTES. Wraps past all-ones to 0 with no flag. The start address is not realigned.
  - WRAP: size = (len+1)*BEAT_BYTES, mask = size-1, next = (addr & ~mask) | ((addr + BEAT_BYTES) & mask).
    - If len+1 is not a power of two, or size > 2^ADDR_W, the burst behaves as INCR.
  - FIXED: next = addr, every beat.
  - Mode 11: identical to INCR.
- abort:
  - In ACTIVE: next cycle is IDLE with addr_valid=0, regardless of addr_ready. Abort has priority over a same-cycle handshake, and that beat counts as delivered.
  - In IDLE: ignored; a simultaneous start_valid is still accepted.
- Reset mid-burst: next cycle shows reset values. The latched descriptor is discarded and no further beats are issued.
- start_valid while ACTIVE: not accepted (start_ready=0). The upstream holds the descriptor.
- Inputs start_addr/start_len/start_mode are sampled only at accept; later changes have no effect on the running burst.

Test Plan:
- Reset with all inputs toggling -> after reset start_ready=1, addr_valid=0, addr_out=0, busy=0.
- INCR, start_addr=0x0000_1000, len=3, addr_ready=1 -> beats 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles starting 1 cycle after accept. addr_last only on 0x1018; start_ready=1 the cycle after.
- WRAP, start_addr=0x0000_1038, len=3 -> 0x1038, 0x1020, 0x1028, 0x1030. WRAP with len=2 -> INCR sequence 0x1038, 0x1040, 0x1048.
- INCR, start_addr=0xFFFF_FFF8, len=1 -> 0xFFFF_FFF8 then 0x0000_0000 with addr_last=1. FIXED, 0x2000, len=2 -> 0x2000 three times, beat_idx 0,1,2.
- Back-pressure: INCR 0x3000 len=1, addr_ready low 4 cycles on beat 0 -> addr_out=0x3000, beat_idx=0 stable for those cycles, then 0x3008. start_valid pulsed mid-burst -> not accepted.
- abort asserted on beat 1 of a len=7 burst with addr_ready=1 -> addr_valid=0 next cycle, start_ready=1. Separately, n_rst=0 on beat 2 -> reset values next cycle, no further beats.

Source files
------------

// File: rtl/burst_addr_gen.sv
// Burst address generator for the DDR column-command path.
// Accepts one descriptor, then emits one beat address per valid/ready handshake.
module burst_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 8,
    parameter int BEAT_BYTES = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [1:0]        start_mode,
    input  logic              abort,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_last,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy
);

    localparam int SW = ADDR_W + LEN_W + 9;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q;
    logic              start_ready_q;
    logic              addr_valid_q;
    logic              addr_last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mask_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;
    logic              fixed_q;
    logic              wrap_q;

    logic [LEN_W:0]    beats;
    logic [SW-1:0]     size;
    logic              pow2;
    logic              fits;
    logic              wrap_d;
    logic [ADDR_W-1:0] mask_d;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] addr_d;

    // Wrap legality is resolved once at accept so the beat path only needs a mask.
    always_comb begin
        beats  = {1'b0, start_len} + {{LEN_W{1'b0}}, 1'b1};
        size   = SW'(beats) * SW'(BEAT_BYTES);
        pow2   = (beats & (beats - {{LEN_W{1'b0}}, 1'b1})) == '0;
        fits   = size <= (SW'(1) << ADDR_W);
        wrap_d = (start_mode == 2'b01) && pow2 && fits;
        mask_d = ADDR_W'(size - SW'(1));
    end

    always_comb begin
        incr = addr_q + ADDR_W'(BEAT_BYTES);
        if (fixed_q) begin
            addr_d = addr_q;
        end else if (wrap_q) begin
            addr_d = (addr_q & ~mask_q) | (incr & mask_q);
        end else begin
            addr_d = incr;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b0;
            addr_valid_q  <= 1'b0;
            addr_last_q   <= 1'b0;
            addr_q        <= '0;
            mask_q        <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            fixed_q       <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_ready_q <= 1'b1;
                    addr_valid_q  <= 1'b0;
                    if (start_valid && start_ready_q) begin
                        state_q       <= ACTIVE;
                        start_ready_q <= 1'b0;
                        addr_valid_q  <= 1'b1;
                        addr_q        <= start_addr;
                        idx_q         <= '0;
                        addr_last_q   <= (start_len == '0);
                        len_q         <= start_len;
                        fixed_q       <= (start_mode == 2'b10);
                        wrap_q        <= wrap_d;
                        mask_q        <= mask_d;
                    end
                end
                ACTIVE: begin
                    // Abort wins over a same-cycle handshake; that beat still counts as taken.
                    if (abort || (addr_ready && addr_last_q)) begin
                        state_q       <= IDLE;
                        start_ready_q <= 1'b1;
                        addr_valid_q  <= 1'b0;
                        addr_last_q   <= 1'b0;
                    end else if (addr_ready) begin
                        addr_q      <= addr_d;
                        idx_q       <= idx_q + LEN_W'(1);
                        addr_last_q <= ((idx_q + LEN_W'(1)) == len_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign addr_valid  = addr_valid_q;
    assign addr_out    = addr_q;
    assign addr_last   = addr_last_q;
    assign beat_idx    = idx_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_burst_addr_gen.sv
// Scoreboard bench for burst_addr_gen: expected beats are queued at descriptor
// drive time from an independent address model and popped on each handshake.
module tb_burst_addr_gen;

    localparam int BB = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] start_addr = '0;
    logic [7:0]  start_len = '0;
    logic [1:0]  start_mode = '0;
    logic        abort = 1'b0;
    logic        addr_valid;
    logic        addr_ready = 1'b0;
    logic [31:0] addr_out;
    logic        addr_last;
    logic [7:0]  beat_idx;
    logic        busy;

    always #5 clk = ~clk;

    burst_addr_gen #(.ADDR_W(32), .LEN_W(8), .BEAT_BYTES(BB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_addr (start_addr),
        .start_len  (start_len),
        .start_mode (start_mode),
        .abort      (abort),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_out   (addr_out),
        .addr_last  (addr_last),
        .beat_idx   (beat_idx),
        .busy       (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    // Wrap modelled as base + offset modulo burst size, in 64-bit arithmetic.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input logic [1:0] m, input int i);
        longint unsigned aa;
        longint unsigned size;
        longint unsigned base;
        bit p2;
        aa   = a;
        size = longint'(len + 1) * BB;
        p2   = ((len + 1) & len) == 0;
        if (m == 2'b10) return a;
        if (m == 2'b01 && p2 && size <= 64'h1_0000_0000) begin
            base = aa - (aa % size);
            return 32'(base + ((aa % size) + longint'(i) * BB) % size);
        end
        return 32'(aa + longint'(i) * BB);
    endfunction

    task automatic send(input logic [31:0] a, input int len, input logic [1:0] m);
        for (int i = 0; i <= len; i++)
            sb.push_back({model_addr(a, len, m, i), 8'(i), (i == len)});
        start_addr  = a;
        start_len   = 8'(len);
        start_mode  = m;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        start_addr  = $urandom;
        start_len   = 8'($urandom);
        start_mode  = 2'($urandom);
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            start_valid = 1'($urandom); abort = 1'($urandom); addr_ready = 1'($urandom);
            start_addr = $urandom; start_len = 8'($urandom); start_mode = 2'($urandom);
            @(negedge clk);
            total_cnt++;
            if ({start_ready, addr_valid, busy} !== 3'b000)
                $display("FAIL reset_hold cyc=%0d got rdy/vld/busy=%b want 000", k, {start_ready, addr_valid, busy});
            else pass_cnt++;
        end
        start_valid = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({start_ready, addr_valid, addr_out, addr_last, beat_idx, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0})
            $display("FAIL reset_release got rdy=%b vld=%b addr=%h last=%b idx=%0d busy=%b want 1 0 0 0 0 0",
                     start_ready, addr_valid, addr_out, addr_last, beat_idx, busy);
        else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_incr;
        logic [31:0] addrs [3];
        int          lens  [3];
        logic [1:0]  modes [3];
        beat_t       exp;
        int          cyc;
        addrs = '{32'h0000_1000, 32'hFFFF_FFF8, 32'h0000_0100};
        lens  = '{3, 1, 0};
        modes = '{2'b00, 2'b00, 2'b11};
        addr_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            send(addrs[t], lens[t], modes[t]);
            total_cnt++;
            if (addr_valid !== 1'b1) $display("FAIL incr_latency burst=%0d got vld=%b want 1", t, addr_valid);
            else pass_cnt++;
            cyc = 0;
            while (sb.size() > 0 && cyc < 40) begin
                if (addr_valid && addr_ready) begin
                    exp = sb.pop_front();
                    total_cnt++;
                    if ({addr_out, beat_idx, addr_last} !== exp)
                        $display("FAIL incr_beat got %h/%0d/%b want %h/%0d/%b", addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
                    else pass_cnt++;
                    $display("incr: beat addr=%h idx=%0d last=%b", addr_out, beat_idx, addr_last);
                end
                @(negedge clk); cyc++;
            end
            total_cnt++;
            if (sb.size() != 0 || addr_valid !== 1'b0 || start_ready !== 1'b1)
                $display("FAIL incr_end left=%0d got vld=%b rdy=%b want 0 left, vld 0 rdy 1", sb.size(), addr_valid, start_ready);
            else pass_cnt++;
            sb.delete();
        end
    endtask

    task automatic test_wrap_fixed;
        logic [31:0] addrs [4];
        int          lens  [4];
        logic [1:0]  modes [4];
        beat_t       exp;
        int          cyc;
        addrs = '{32'h0000_1038, 32'h0000_1038, 32'h0000_2018, 32'h0000_2000};
        lens  = '{3, 2, 1, 2};
        modes = '{2'b01, 2'b01, 2'b01, 2'b10};
        addr_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send(addrs[t], lens[t], modes[t]);
            cyc = 0;
            while (sb.size() > 0 && cyc < 40) begin
                if (addr_valid && addr_ready) begin
                    exp = sb.pop_front();
                    total_cnt++;
                    if ({addr_out, beat_idx, addr_last} !== exp)
                        $display("FAIL mode%0d_beat got %h/%0d/%b want %h/%0d/%b", modes[t], addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
                    else pass_cnt++;
                    $display("mode%0d: beat addr=%h idx=%0d last=%b", modes[t], addr_out, beat_idx, addr_last);
                end
                @(negedge clk); cyc++;
            end
            total_cnt++;
            if (sb.size() != 0 || addr_valid !== 1'b0 || start_ready !== 1'b1)
                $display("FAIL mode_end left=%0d got vld=%b rdy=%b want 0 left, vld 0 rdy 1", sb.size(), addr_valid, start_ready);
            else pass_cnt++;
            sb.delete();
        end
    endtask

    task automatic test_backpressure;
        beat_t exp;
        int    cyc;
        addr_ready = 1'b0;
        send(32'h0000_3000, 1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if ({addr_valid, addr_out, beat_idx, addr_last, start_ready} !== {1'b1, 32'h3000, 8'd0, 1'b0, 1'b0})
                $display("FAIL bp_hold cyc=%0d got vld=%b addr=%h idx=%0d last=%b rdy=%b want 1 3000 0 0 0",
                         k, addr_valid, addr_out, beat_idx, addr_last, start_ready);
            else pass_cnt++;
            start_valid = (k == 1);
            @(negedge clk);
        end
        start_valid = 1'b0;
        addr_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (addr_valid && addr_ready) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({addr_out, beat_idx, addr_last} !== exp)
                    $display("FAIL bp_beat got %h/%0d/%b want %h/%0d/%b", addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
                else pass_cnt++;
                $display("bp: beat addr=%h idx=%0d last=%b", addr_out, beat_idx, addr_last);
            end
            @(negedge clk); cyc++;
        end
        total_cnt++;
        if (sb.size() != 0 || addr_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL bp_end left=%0d got vld=%b rdy=%b want 0 left, vld 0 rdy 1", sb.size(), addr_valid, start_ready);
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_abort;
        beat_t exp;
        int    cyc;
        addr_ready = 1'b1;
        send(32'h0000_4000, 7, 2'b00);
        for (int k = 0; k < 2; k++) begin
            exp = sb.pop_front();
            total_cnt++;
            if (!addr_valid || {addr_out, beat_idx, addr_last} !== exp)
                $display("FAIL abort_beat got vld=%b %h/%0d/%b want %h/%0d/%b", addr_valid, addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
            else pass_cnt++;
            if (k == 1) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        total_cnt++;
        if ({addr_valid, start_ready, busy} !== 3'b010)
            $display("FAIL abort_idle got vld/rdy/busy=%b want 010", {addr_valid, start_ready, busy});
        else pass_cnt++;
        $display("abort: burst cancelled after beat 1");
        sb.delete();
        abort = 1'b1;
        send(32'h0000_4100, 0, 2'b00);
        abort = 1'b0;
        cyc = 0;
        while (sb.size() > 0 && cyc < 40) begin
            if (addr_valid && addr_ready) begin
                exp = sb.pop_front();
                total_cnt++;
                if ({addr_out, beat_idx, addr_last} !== exp)
                    $display("FAIL abort_idle_accept got %h/%0d/%b want %h/%0d/%b", addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
                else pass_cnt++;
                $display("abort: idle-abort beat addr=%h", addr_out);
            end
            @(negedge clk); cyc++;
        end
        total_cnt++;
        if (sb.size() != 0 || addr_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL abort_idle_end left=%0d got vld=%b rdy=%b want 0 left, vld 0 rdy 1", sb.size(), addr_valid, start_ready);
        else pass_cnt++;
        sb.delete();
    endtask

    task automatic test_reset_midburst;
        beat_t exp;
        int    stray;
        addr_ready = 1'b1;
        send(32'h0000_5000, 7, 2'b00);
        for (int k = 0; k < 3; k++) begin
            exp = sb.pop_front();
            total_cnt++;
            if (!addr_valid || {addr_out, beat_idx, addr_last} !== exp)
                $display("FAIL rst_beat got vld=%b %h/%0d/%b want %h/%0d/%b", addr_valid, addr_out, beat_idx, addr_last, exp.addr, exp.idx, exp.last);
            else pass_cnt++;
            if (k == 2) n_rst = 1'b0;
            @(negedge clk);
        end
        n_rst = 1'b1;
        sb.delete();
        total_cnt++;
        if ({start_ready, addr_valid, addr_out, addr_last, beat_idx, busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0})
            $display("FAIL rst_mid got rdy=%b vld=%b addr=%h last=%b idx=%0d busy=%b want 0 0 0 0 0 0",
                     start_ready, addr_valid, addr_out, addr_last, beat_idx, busy);
        else pass_cnt++;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (addr_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray != 0 || start_ready !== 1'b1)
            $display("FAIL rst_after got stray=%0d rdy=%b want 0 stray rdy 1", stray, start_ready);
        else pass_cnt++;
        $display("reset_mid: burst discarded");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_backpressure();
        test_abort();
        test_reset_midburst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
